// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory load/store path.
package rv_mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  // Request fields kept for the lifetime of one transaction.
  typedef struct packed {
    logic            we;
    size_e           size;
    logic            is_unsigned;
    logic [1:0]      lane;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Natural-alignment check; byte accesses are always aligned.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = lo[0];
      SZ_W:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Requests that complete with an error and never touch memory.
  function automatic logic is_bad_req(input size_e size, input logic [1:0] lo);
    return (size == SZ_X) || is_misaligned(size, lo);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// CPU request/response and data-memory signals of the load/store port.
interface lsu_mem_port_if;
  import rv_mem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_enable;
  logic            mem_read;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_read, mem_addr, mem_wdata
  );

  // CPU plus memory environment side.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_read, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with extension, and store-lane merge into an old word.
module lsu_lane_align
  import rv_mem_pkg::*;
(
  input  size_e           size_i,
  input  logic [1:0]      lane_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian lane select, then extend for loads or splice for stores.
  always_comb begin
    lane_b       = rdata_i[{lane_i, 3'b000} +: 8];
    lane_h       = rdata_i[{lane_i[1], 4'b0000} +: 16];
    load_data_c  = rdata_i;
    merge_data_c = rdata_i;
    case (size_i)
      SZ_B: begin
        load_data_c = uns_i ? XLEN'(lane_b) : {{(XLEN-8){lane_b[7]}}, lane_b};
        merge_data_c[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_data_c = uns_i ? XLEN'(lane_h) : {{(XLEN-16){lane_h[15]}}, lane_h};
        merge_data_c[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_c  = rdata_i;
        merge_data_c = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: byte-addressed CPU requests to a word-organised data memory.
module lsu_mem_port
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_IDX_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_port_if.slave bus
);

  state_e          state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_enable_q, mem_enable_d;
  logic            mem_read_q, mem_read_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            accept_c;
  logic            bad_c;
  size_e           size_c;
  logic [XLEN-1:0] mem_idx_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] merge_data_c;

  assign size_c    = size_e'(bus.req_size);
  assign accept_c  = bus.req_valid && req_ready_q;
  assign bad_c     = is_bad_req(size_c, bus.req_addr[1:0]);
  assign mem_idx_c = XLEN'(bus.req_addr[MEM_IDX_W+1:2]);

  // Read data is consumed only in WAIT, against the captured request.
  lsu_lane_align u_align (
    .size_i       (req_q.size),
    .lane_i       (req_q.lane),
    .uns_i        (req_q.is_unsigned),
    .rdata_i      (bus.mem_rdata),
    .wdata_i      (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_enable_d = 1'b0;
    mem_read_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_d = '{we:          bus.req_we,
                    size:        size_c,
                    is_unsigned: bus.req_unsigned,
                    lane:        bus.req_addr[1:0],
                    wdata:       bus.req_wdata};
          resp_rdata_d = '0;
          resp_err_d   = bad_c;
          if (bad_c) begin
            state_d = RESP;
          end else if (!bus.req_we || (size_c != SZ_W)) begin
            state_d      = RD;
            mem_enable_d = 1'b1;
            mem_read_d   = 1'b1;
            mem_addr_d   = mem_idx_c;
          end else begin
            state_d      = WR;
            mem_enable_d = 1'b1;
            mem_addr_d   = mem_idx_c;
            mem_wdata_d  = bus.req_wdata;
          end
        end
      end
      RD: state_d = WAIT;
      WAIT: begin
        if (req_q.we) begin
          state_d      = WR;
          mem_enable_d = 1'b1;
          mem_wdata_d  = merge_data_c;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_data_c;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == IDLE);
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_enable_q <= mem_enable_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a transaction-level reference model.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst_n;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.MEM_IDX_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory: one-cycle registered read, write when enabled with read low.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_enable) begin
      if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      else              mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } txn_t;

  txn_t        q[$];
  logic [31:0] shadow [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          accepts = 0;
  int          resps = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  logic [31:0] seen_rdata = 32'h0;
  logic        seen_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_err(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int f_lat(input txn_t t);
    if (f_err(t.size, t.addr)) return 1;
    if (!t.we)                 return 3;
    if (t.size == 2'd2)        return 2;
    return 4;
  endfunction

  function automatic int f_shift(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] size,
                                         input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int sh;
    sh = f_shift(size, a);
    if (size == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [1:0] size,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wd;
    sh   = f_shift(size, a);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Accept monitor: records each handshake with the cycle that follows it.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst_n && bus.req_valid && bus.req_ready) begin
        t.we    = bus.req_we;
        t.size  = bus.req_size;
        t.uns   = bus.req_unsigned;
        t.addr  = bus.req_addr;
        t.wdata = bus.req_wdata;
        t.acc   = cyc;
        q.push_back(t);
        accepts = accepts + 1;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial begin
    txn_t        t;
    int          k, lat;
    logic        err, sub, exp_rd, exp_wr;
    logic [31:0] idx, exp_wd, exp_rdata, old_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        last_rdata = 32'h0;
        last_err   = 1'b0;
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
        chk("rst_mem_addr",   bus.mem_addr,        32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
      end else if (q.size() == 0) begin
        chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_req_ready",  32'(bus.req_ready),  32'd1);
        chk("idle_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("idle_mem_wdata",  bus.mem_wdata,       32'd0);
        chk("hold_resp_rdata", bus.resp_rdata,      last_rdata);
        chk("hold_resp_err",   32'(bus.resp_err),   32'(last_err));
      end else begin
        t      = q[0];
        k      = cyc - t.acc + 1;
        lat    = f_lat(t);
        err    = f_err(t.size, t.addr);
        sub    = t.we && (t.size != 2'd2);
        idx    = 32'(t.addr[17:2]);
        old_w  = shadow[idx[7:0]];
        exp_rd = !err && !t.we && (k == 1) || !err && sub && (k == 1);
        exp_wr = !err && t.we && !sub && (k == 1) || !err && sub && (k == 3);
        exp_wd = exp_wr ? f_merge(old_w, t.size, t.addr, t.wdata) : 32'h0;
        chk("busy_req_ready", 32'(bus.req_ready),  32'd0);
        chk("resp_valid",     32'(bus.resp_valid), 32'(k == lat));
        chk("mem_enable",     32'(bus.mem_enable), 32'(exp_rd || exp_wr));
        if (exp_rd || exp_wr) begin
          chk("mem_read", 32'(bus.mem_read), 32'(exp_rd));
          chk("mem_addr", bus.mem_addr, idx);
        end
        chk("mem_wdata", bus.mem_wdata, exp_wd);
        if (k >= lat) begin
          exp_rdata = (err || t.we) ? 32'h0 : f_load(old_w, t.size, t.uns, t.addr);
          chk("resp_err",   32'(bus.resp_err), 32'(err));
          chk("resp_rdata", bus.resp_rdata,    exp_rdata);
          last_rdata = exp_rdata;
          last_err   = err;
          if (!err && t.we) shadow[idx[7:0]] = f_merge(old_w, t.size, t.addr, t.wdata);
          seen_rdata = bus.resp_rdata;
          seen_err   = bus.resp_err;
          resps      = resps + 1;
          void'(q.pop_front());
        end
      end
    end
  end

  // Drive one request from a negedge; optionally leave req_valid high afterwards.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int n;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_req_ready actual=0 expected=1 t=%0t", $time);
    end
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_response actual=pending expected=done t=%0t", $time);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    issue(we, sz, uns, addr, wd, 1'b0);
    wait_done();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        uns;
    logic [31:0] exp;
  } ldvec_t;

  initial begin
    ldvec_t bl [5];
    int r0, a0;

    bl[0] = '{32'h20, 1'b0, 32'h0000_0001};
    bl[1] = '{32'h21, 1'b0, 32'h0000_007F};
    bl[2] = '{32'h22, 1'b0, 32'hFFFF_FFFF};
    bl[3] = '{32'h23, 1'b0, 32'hFFFF_FF80};
    bl[4] = '{32'h22, 1'b1, 32'h0000_00FF};

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load, plus an aliased address above the index bits.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("lit_mem_w4", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lit_ld_10", seen_rdata, 32'hDEAD_BEEF);
    chk("lit_ld_10_err", 32'(seen_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0004_0010, 32'h0);
    chk("lit_ld_alias", seen_rdata, 32'hDEAD_BEEF);

    // Byte loads, signed and unsigned.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 2'd0, bl[i].uns, bl[i].addr, 32'h0);
      chk($sformatf("lit_ldb_%0d", i), seen_rdata, bl[i].exp);
    end

    // Sub-word stores via read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_00AA);
    chk("lit_mem_sb", mem[12], 32'h1122_AA44);
    do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_BEEF);
    chk("lit_mem_sh", mem[12], 32'hBEEF_AA44);
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0);
    chk("lit_ldh_s", seen_rdata, 32'hFFFF_BEEF);
    do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0);
    chk("lit_ldh_u", seen_rdata, 32'h0000_AA44);

    // Error requests.
    do_req(1'b1, 2'd1, 1'b0, 32'h41, 32'h1234);
    chk("lit_err_h", 32'(seen_err), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    chk("lit_err_w", 32'(seen_err), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    chk("lit_err_sz", 32'(seen_err), 32'd1);
    chk("lit_err_rdata", seen_rdata, 32'h0);

    // Reset during WAIT of a sub-word store.
    do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h5566_7788);
    r0 = resps;
    issue(1'b1, 2'd0, 1'b0, 32'h51, 32'h0000_00CC, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("arst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_mem_wdata",  bus.mem_wdata,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_mem_after_rst", mem[20], 32'h5566_7788);
    chk("no_resp_after_rst", 32'(resps - r0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
    chk("lit_ld_after_rst", seen_rdata, 32'h5566_7788);

    // Back-to-back with req_valid held high.
    a0 = accepts;
    r0 = resps;
    issue(1'b1, 2'd2, 1'b0, 32'h60, 32'h1234_5678, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h61, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h62, 32'h0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("b2b_accepts", 32'(accepts - a0), 32'd3);
    chk("b2b_resps",   32'(resps - r0),   32'd3);
    chk("lit_b2b_ld",  seen_rdata,        32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting between the CPU execute stage and the word-organised data memory (32-bit words, one-cycle registered read, write on enable with read low).
- Converts byte-addressed load/store requests of byte, halfword or word size into word accesses.
- Handles lane extraction and sign or zero extension for loads, and read-modify-write for sub-word stores.
- Returns a single-cycle response to the CPU.

Parameters:
- MEM_IDX_W, 16, number of word-index bits forwarded to memory. mem_addr = zero-extended req_addr[MEM_IDX_W+1:2]; higher address bits are ignored, so accesses alias.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size; valid with resp_valid
- mem_enable  out  1  memory enable
- mem_read  out  1  1 = read, 0 = write
- mem_addr  out  32  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid the cycle after the read cycle

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE.
- Reset is asynchronous. Asserting it mid-operation drops mem_enable immediately and discards the in-flight request. No response is produced for that request.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. All req_* fields are captured into registers at that edge.
- Memory-side outputs are driven only from the state and the captured registers. There is no combinational path from req_* to mem_*.
- Alignment: half is misaligned if addr[0]=1; word is misaligned if addr[1:0]!=0. Misaligned requests and size 11 go IDLE->RESP with resp_err=1 and no memory access.
- Lanes are little-endian: byte k = bits 8k+7:8k with k = addr[1:0]; half h = bits 16h+15:16h with h = addr[1].
- State machine:
  - IDLE: req_ready=1. On accept:
    - error -> RESP
    - load, or sub-word store -> RD
    - word store -> WR
  - RD: mem_enable=1, mem_read=1, mem_addr=word index. -> WAIT.
  - WAIT: mem_enable=0; mem_rdata is valid this cycle.
    - Load: latch the extended lane into resp_rdata -> RESP.
    - Sub-word store: latch the merged word (old word with the selected lane replaced by req_wdata low bits) -> WR.
  - WR: mem_enable=1, mem_read=0, mem_wdata = full word or merged word. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE. resp_rdata and resp_err hold until the next accept.
- Latency, counted in cycles after the accept edge that resp_valid is high:
  - load: 3rd cycle
  - word store: 2nd cycle
  - sub-word store: 4th cycle
  - error: 1st cycle
- Throughput: the earliest next accept is the cycle after RESP, since req_ready is low in RESP.
- resp_valid has no backpressure; the CPU must sample it.
- mem_wdata is 0 outside WR. mem_addr holds its value outside RD/WR.

Decomposition:
- Package rv_mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W
  - state enum IDLE, RD, WAIT, WR, RESP
  - a misalignment function shared with the fetch path
- Sub-module lsu_lane_align: purely combinational. It performs lane extraction with sign/zero extension and store-lane merge, and is instanced once in WAIT logic.

Test Plan:
- Word store then load at 0x0000_0010:
  - Store 0xDEADBEEF: one write cycle with mem_addr=4.
  - Load: resp_rdata=0xDEADBEEF on the 3rd cycle after accept, resp_err=0.
- Byte loads from word 0x80FF7F01 at 0x20..0x23, signed:
  - Expect 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Unsigned at 0x22 -> 0x000000FF.
- Sub-word store with word 0x11223344 preset at 0x30:
  - Store byte 0xAA at 0x31 -> memory reads 0x1122AA44.
  - Store half 0xBEEF at 0x32 -> memory reads 0xBEEFAA44.
  - Sequence is RD, WAIT, WR; resp_valid on the 4th cycle.
- Errors: half at 0x41, word at 0x42, size 11 at 0x40:
  - Each gives resp_err=1 on the 1st cycle after accept.
  - mem_enable never rises.
- Reset mid-operation: assert rst_n low during WAIT of a sub-word store.
  - Memory is unchanged, all outputs are at reset values immediately, and no resp_valid is seen.
  - A subsequent load after release works normally.
- Back-to-back:
  - req_valid held high with 3 queued requests -> exactly one accept per transaction.
  - req_ready is low from the accept edge through RESP, and requests are never dropped or duplicated.
